// File: rtl/grad_update_pkg.sv
// Shared state encoding and fixed-point helpers for the weight-gradient update block.
// Helpers work on a 128-bit signed container so any WIDTH up to 64 fits without overflow.
package grad_update_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int FRAC_DEF  = 24;
  localparam int MAXW      = 64;
  localparam int WW        = 2 * MAXW;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC   = 3'd1,
    DRAIN = 3'd2,
    UPD   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Symmetric clamp to a w-bit signed range; the most-negative code is never produced.
  function automatic logic signed [WW-1:0] sat_w(input logic signed [WW-1:0] v, input int w);
    logic signed [WW-1:0] one;
    logic signed [WW-1:0] lim;
    one = 1;
    lim = (one <<< (w - 1)) - one;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // Full-width product, arithmetic shift floors toward negative infinity.
  function automatic logic signed [WW-1:0] mul_shift(input logic signed [WW-1:0] a,
                                                     input logic signed [WW-1:0] b,
                                                     input int frac);
    return (a * b) >>> frac;
  endfunction

endpackage

// File: rtl/grad_acc.sv
// Saturating gradient accumulator with GUARD headroom bits; dw is the accumulator clamped to WIDTH.
// Latency 1 cycle per add; no backpressure, en qualifies each incoming product.
module grad_acc
  import grad_update_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GUARD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WW-1:0]    prod,
  output logic [WIDTH-1:0] dw
);

  localparam int AW  = WIDTH + GUARD;
  localparam int EXT = WW - AW;

  logic [AW-1:0]        acc;
  logic signed [WW-1:0] acc_ext;
  logic signed [WW-1:0] sum;
  logic signed [WW-1:0] acc_sat;
  logic signed [WW-1:0] dw_sat;
  logic                 unused_bits;

  assign acc_ext = {{EXT{acc[AW-1]}}, acc};
  assign sum     = acc_ext + prod;
  // Clamp instead of wrapping so long runs of large products pin at full scale.
  assign acc_sat = sat_w(sum, AW);
  assign dw_sat  = sat_w(acc_ext, WIDTH);
  assign dw      = dw_sat[WIDTH-1:0];

  assign unused_bits = ^{acc_sat[WW-1:AW], dw_sat[WW-1:WIDTH]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_sat[AW-1:0];
    end
  end

endmodule

// File: rtl/grad_update.sv
// Weight-gradient update: w -= lr * sum_t(dgate*x) over an N_CELL x N_IN matrix, one element at a time.
// Latency TIMESTEP+2 cycles per element, one write each; no backpressure, reads assume fixed 1-cycle memories.
module grad_update
  import grad_update_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int N_IN     = 53,
  parameter int N_CELL   = 8,
  parameter int TIMESTEP = 1,
  parameter int ADDR     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] i_lr,
  output logic [ADDR-1:0]  rd_addr_dgate,
  input  logic [WIDTH-1:0] i_dgate,
  output logic [ADDR-1:0]  rd_addr_x,
  input  logic [WIDTH-1:0] i_x,
  output logic [ADDR-1:0]  rd_addr_w,
  input  logic [WIDTH-1:0] i_w,
  output logic             wr_w,
  output logic [ADDR-1:0]  wr_addr_w,
  output logic [WIDTH-1:0] o_w,
  output logic             busy,
  output logic             done
);

  localparam int EXT = WW - WIDTH;
  localparam logic [ADDR-1:0] T_LAST   = ADDR'(TIMESTEP - 1);
  localparam logic [ADDR-1:0] K_LAST   = ADDR'(N_IN - 1);
  localparam logic [ADDR-1:0] C_LAST   = ADDR'(N_CELL - 1);
  localparam logic [ADDR-1:0] N_IN_A   = ADDR'(N_IN);
  localparam logic [ADDR-1:0] N_CELL_A = ADDR'(N_CELL);

  state_t               state, state_nx;
  logic [ADDR-1:0]      c_idx, k_idx, t_idx;
  logic [ADDR-1:0]      elem_addr;
  logic [WIDTH-1:0]     lr_q, w_q, dw;
  logic                 rd_vld, rd_first;
  logic                 last_t, last_elem;
  logic signed [WW-1:0] dg_ext, x_ext, dw_ext, lr_ext, w_ext;
  logic signed [WW-1:0] prod, step, new_w;
  logic                 unused_bits;

  assign last_t    = (t_idx == T_LAST);
  assign last_elem = (c_idx == C_LAST) && (k_idx == K_LAST);
  assign elem_addr = c_idx * N_IN_A + k_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    busy          = 1'b1;
    done          = 1'b0;
    wr_w          = 1'b0;
    wr_addr_w     = '0;
    rd_addr_dgate = '0;
    rd_addr_x     = '0;
    rd_addr_w     = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ACC;
      end
      ACC: begin
        rd_addr_dgate = t_idx * N_CELL_A + c_idx;
        rd_addr_x     = t_idx * N_IN_A + k_idx;
        if (t_idx == '0) rd_addr_w = elem_addr;
        if (last_t) state_nx = DRAIN;
      end
      DRAIN: state_nx = UPD;
      UPD: begin
        wr_w      = 1'b1;
        wr_addr_w = elem_addr;
        state_nx  = last_elem ? DONE : ACC;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read data lands one cycle after its address, so the valid flags trail the state by one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_idx    <= '0;
      k_idx    <= '0;
      t_idx    <= '0;
      lr_q     <= '0;
      w_q      <= '0;
      rd_vld   <= 1'b0;
      rd_first <= 1'b0;
    end else begin
      rd_vld   <= (state == ACC);
      rd_first <= (state == ACC) && (t_idx == '0);
      if (rd_first) w_q <= i_w;
      case (state)
        IDLE: begin
          if (start) begin
            lr_q  <= i_lr;
            c_idx <= '0;
            k_idx <= '0;
            t_idx <= '0;
          end
        end
        ACC: t_idx <= last_t ? '0 : t_idx + 1'b1;
        UPD: begin
          if (k_idx == K_LAST) begin
            k_idx <= '0;
            c_idx <= last_elem ? '0 : c_idx + 1'b1;
          end else begin
            k_idx <= k_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dg_ext = {{EXT{i_dgate[WIDTH-1]}}, i_dgate};
  assign x_ext  = {{EXT{i_x[WIDTH-1]}}, i_x};
  assign prod   = mul_shift(dg_ext, x_ext, FRAC);

  grad_acc #(
    .WIDTH (WIDTH),
    .GUARD (8)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state == ACC) && (t_idx == '0)),
    .en   (rd_vld),
    .prod (prod),
    .dw   (dw)
  );

  assign dw_ext = {{EXT{dw[WIDTH-1]}}, dw};
  assign lr_ext = {{EXT{lr_q[WIDTH-1]}}, lr_q};
  assign w_ext  = {{EXT{w_q[WIDTH-1]}}, w_q};
  assign step   = sat_w(mul_shift(dw_ext, lr_ext, FRAC), WIDTH);
  assign new_w  = sat_w(w_ext - step, WIDTH);
  assign o_w    = (state == UPD) ? new_w[WIDTH-1:0] : '0;

  assign unused_bits = ^{new_w[WW-1:WIDTH]};

endmodule

// File: tb/tb_grad_update.sv
// Bench for grad_update: a 2x3x2 instance against a memory model and reference math,
// plus two 1x1 instances for the fixed-value timing and saturation cases.
module tb_grad_update;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Main instance: N_CELL=2, N_IN=3, TIMESTEP=2
  logic        a_start;
  logic [31:0] a_lr, a_dg, a_x, a_w, a_ow;
  logic [8:0]  a_rd_dg, a_rd_x, a_rd_w, a_wr_addr;
  logic        a_wr, a_busy, a_done;
  int          dg_mem [512];
  int          x_mem  [512];
  int          w_mem  [512];
  logic [31:0] exp_w  [6];

  grad_update #(.N_IN(3), .N_CELL(2), .TIMESTEP(2)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .i_lr(a_lr),
    .rd_addr_dgate(a_rd_dg), .i_dgate(a_dg), .rd_addr_x(a_rd_x), .i_x(a_x),
    .rd_addr_w(a_rd_w), .i_w(a_w), .wr_w(a_wr), .wr_addr_w(a_wr_addr), .o_w(a_ow),
    .busy(a_busy), .done(a_done)
  );

  always @(posedge clk) begin
    a_dg <= dg_mem[a_rd_dg];
    a_x  <= x_mem[a_rd_x];
    a_w  <= w_mem[a_rd_w];
  end

  // 1x1 instances with constant read data
  logic        s_start;
  logic [31:0] b_lr, b_dg, b_x, b_w, b_ow, c_lr, c_dg, c_x, c_w, c_ow;
  logic [8:0]  b_rd_dg, b_rd_x, b_rd_w, b_wr_addr, c_rd_dg, c_rd_x, c_rd_w, c_wr_addr;
  logic        b_wr, b_busy, b_done, c_wr, c_busy, c_done;

  grad_update #(.N_IN(1), .N_CELL(1), .TIMESTEP(1)) u_b (
    .clk(clk), .rst(rst), .start(s_start), .i_lr(b_lr),
    .rd_addr_dgate(b_rd_dg), .i_dgate(b_dg), .rd_addr_x(b_rd_x), .i_x(b_x),
    .rd_addr_w(b_rd_w), .i_w(b_w), .wr_w(b_wr), .wr_addr_w(b_wr_addr), .o_w(b_ow),
    .busy(b_busy), .done(b_done)
  );

  grad_update #(.N_IN(1), .N_CELL(1), .TIMESTEP(4)) u_c (
    .clk(clk), .rst(rst), .start(s_start), .i_lr(c_lr),
    .rd_addr_dgate(c_rd_dg), .i_dgate(c_dg), .rd_addr_x(c_rd_x), .i_x(c_x),
    .rd_addr_w(c_rd_w), .i_w(c_w), .wr_w(c_wr), .wr_addr_w(c_wr_addr), .o_w(c_ow),
    .busy(c_busy), .done(c_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input longint lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // Reference: per element, sum floor(dg*x/2^24) over timesteps in a 40-bit clamped sum,
  // then w - floor(sat32(sum)*lr/2^24), all clamped to the symmetric 32-bit range.
  task automatic model(input int lr);
    longint lim32, lim40, acc, p, dwv, st, nw;
    int c, k;
    lim32 = 64'sd2147483647;
    lim40 = 64'sd549755813887;
    for (int e = 0; e < 6; e++) begin
      c = e / 3;
      k = e % 3;
      acc = 0;
      for (int t = 0; t < 2; t++) begin
        p   = (longint'(dg_mem[t*2+c]) * longint'(x_mem[t*3+k])) >>> 24;
        acc = clamp(acc + p, lim40);
      end
      dwv = clamp(acc, lim32);
      st  = clamp((dwv * longint'(lr)) >>> 24, lim32);
      nw  = clamp(longint'(w_mem[e]) - st, lim32);
      exp_w[e] = 32'(nw);
    end
  endtask

  function automatic int rnd_val();
    case ($urandom_range(0, 3))
      0:       return int'($urandom);
      1:       return int'($urandom) >>> 4;
      default: return int'($urandom) >>> 7;
    endcase
  endfunction

  task automatic fill(input bit sat);
    for (int i = 0; i < 6; i++) begin
      dg_mem[i] = sat ? 32'h7F00_0000 : rnd_val();
      x_mem[i]  = sat ? 32'h7F00_0000 : rnd_val();
      w_mem[i]  = sat ? 0 : rnd_val();
    end
  endtask

  // Called and returns at a negedge. mode 0: plain run; 1: stray start pulses; 2: reset abort.
  task automatic run_op(input int mode, input int lr);
    int nwr, ndone, done_n, e, ph, post_wr, post_busy;
    model(lr);
    a_lr    = lr;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_lr    = $urandom;
    nwr = 0; ndone = 0; done_n = 0;
    for (int n = 1; n <= 26; n++) begin
      e  = (n - 1) / 4;
      ph = (n - 1) % 4;
      if (n == 1) chk("busy_on", a_busy, 1);
      if (e < 6 && ph < 2) begin
        chk("dg_addr", a_rd_dg, ph*2 + e/3);
        chk("x_addr", a_rd_x, ph*3 + e%3);
      end
      if (a_wr) begin
        if (nwr < 6) begin
          chk("wr_cyc", n, nwr*4 + 4);
          chk("wr_addr", a_wr_addr, nwr);
          chk("wr_dat", a_ow, exp_w[nwr]);
        end else begin
          chk("extra_wr", 1, 0);
        end
        nwr++;
      end
      if (a_done) begin
        ndone++;
        done_n = n;
      end
      if (mode == 2 && n == 12) begin
        rst = 1'b0;
        #1;
        chk("rst_wr", a_wr, 0);
        chk("rst_ow", a_ow, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_waddr", a_wr_addr, 0);
        chk("rst_dgaddr", a_rd_dg, 0);
        chk("abort_wr_cnt", nwr, 3);
        break;
      end
      if (n == 26) begin
        chk("idle_after_done", a_busy, 0);
        a_start = 1'b0;
      end else begin
        a_start = (mode == 1) && (n == 9 || n == 25);
        @(negedge clk);
      end
    end
    if (mode == 2) begin
      repeat (2) @(negedge clk);
      rst = 1'b1;
      post_wr = 0; post_busy = 0;
      repeat (12) begin
        @(negedge clk);
        if (a_wr) post_wr++;
        if (a_busy) post_busy++;
      end
      chk("post_rst_wr", post_wr, 0);
      chk("post_rst_busy", post_busy, 0);
    end else begin
      chk("wr_cnt", nwr, 6);
      chk("done_cnt", ndone, 1);
      chk("done_cyc", done_n, 25);
    end
  endtask

  task automatic run_small();
    int bw, bd, cw, cd;
    bw = 0; bd = 0; cw = 0; cd = 0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      if (b_wr) begin
        chk("b_wr_cyc", n, 3);
        chk("b_wr_addr", b_wr_addr, 0);
        chk("b_wr_dat", b_ow, 32'h00E0_0000);
        bw++;
      end
      if (b_done) begin
        chk("b_done_cyc", n, 4);
        bd++;
      end
      if (c_wr) begin
        chk("c_wr_cyc", n, 6);
        chk("c_wr_dat", c_ow, 32'h8000_0001);
        cw++;
      end
      if (c_done) begin
        chk("c_done_cyc", n, 7);
        cd++;
      end
      @(negedge clk);
    end
    chk("b_wr_cnt", bw, 1);
    chk("b_done_cnt", bd, 1);
    chk("c_wr_cnt", cw, 1);
    chk("c_done_cnt", cd, 1);
    chk("b_idle", b_busy, 0);
  endtask

  initial begin
    int lr_keep;
    a_start = 1'b0;
    s_start = 1'b0;
    a_lr    = '0;
    b_dg = 32'h0100_0000; b_x = 32'h0080_0000; b_w = 32'h0100_0000; b_lr = 32'h0040_0000;
    c_dg = 32'h7F00_0000; c_x = 32'h7F00_0000; c_w = 32'h0000_0000; c_lr = 32'h0100_0000;
    #1 rst = 1'b0;
    #11;
    chk("rst_busy0", a_busy, 0);
    chk("rst_done0", a_done, 0);
    chk("rst_wr0", a_wr, 0);
    chk("rst_ow0", a_ow, 0);
    chk("rst_rdw0", a_rd_w, 0);
    chk("rst_rdx0", a_rd_x, 0);
    chk("rst_waddr0", a_wr_addr, 0);
    chk("rst_b_busy0", b_busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_small();

    fill(1'b1);
    run_op(0, 32'h0100_0000);
    chk("sat_w0", exp_w[0], 32'h8000_0001);

    for (int i = 0; i < 3; i++) begin
      fill(1'b0);
      run_op(0, rnd_val());
    end

    fill(1'b0);
    run_op(1, rnd_val());
    fill(1'b0);
    run_op(0, rnd_val());

    fill(1'b0);
    lr_keep = rnd_val();
    run_op(2, lr_keep);
    run_op(0, lr_keep);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
